// File: rtl/cmp_pkg.sv
// Shared types for the pipelined compare unit and the branch unit.
// Holds the condition-select enum and the N/Z/C/V flag bundle.
package cmp_pkg;

    typedef enum logic [2:0] {
        EQ  = 3'b000,
        NE  = 3'b001,
        LT  = 3'b010,
        GE  = 3'b011,
        LTU = 3'b100,
        GEU = 3'b101,
        LE  = 3'b110,
        GT  = 3'b111
    } cmp_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_cond_eval.sv
// Combinational condition evaluator: (flags, op) -> cond.
// Ports: flags (N/Z/C/V of a-b), op (condition select), cond (result bit).
module cmp_cond_eval
    import cmp_pkg::*;
(
    input  cmp_flags_t flags,
    input  cmp_op_e    op,
    output logic       cond
);

    logic lt;

    always_comb begin
        // Signed less-than: sign of the true difference.
        lt   = flags.n ^ flags.v;
        cond = 1'b0;
        unique case (op)
            EQ:  cond = flags.z;
            NE:  cond = ~flags.z;
            LT:  cond = lt;
            GE:  cond = ~lt;
            LTU: cond = ~flags.c;
            GEU: cond = flags.c;
            LE:  cond = flags.z | lt;
            GT:  cond = ~flags.z & ~lt;
        endcase
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined compare unit with valid/ready on both sides.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, a, b, op,
// in_tag; out_valid/out_ready, result, taken, flags, out_tag.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             taken,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    cmp_op_e          s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    cmp_flags_t       s2_flags;
    cmp_op_e          s2_op;
    logic [TAG_W-1:0] s2_tag;

    logic             en;
    logic [WIDTH:0]   sum;
    cmp_flags_t       s1_flags;
    logic             cond;

    // Whole pipe advances together; an empty S2 always lets it move,
    // which collapses bubbles.
    assign en       = ~s2_valid | out_ready;
    assign in_ready = en;

    // a - b as a + ~b + 1, one bit wider so the top bit is the carry.
    assign sum = {1'b0, s1_a} + {1'b0, ~s1_b}
               + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        s1_flags.n = sum[WIDTH-1];
        s1_flags.z = (sum[WIDTH-1:0] == '0);
        s1_flags.c = sum[WIDTH];
        s1_flags.v = (s1_a[WIDTH-1] != s1_b[WIDTH-1])
                  && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= EQ;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_flags <= '0;
            s2_op    <= EQ;
            s2_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= cmp_op_e'(op);
            s1_tag   <= in_tag;
            s2_valid <= s1_valid;
            s2_flags <= s1_flags;
            s2_op    <= s1_op;
            s2_tag   <= s1_tag;
        end
    end

    cmp_cond_eval u_eval (
        .flags (s2_flags),
        .op    (s2_op),
        .cond  (cond)
    );

    assign out_valid = s2_valid;
    assign result    = {{(WIDTH-1){1'b0}}, cond};
    assign taken     = cond;
    assign flags     = s2_flags;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: table-driven streaming vectors
// plus hand-written backpressure and mid-flight reset sequences.
module tb_cmp_pipe;
    import cmp_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             taken;
    logic [3:0]       flags;
    logic [TAG_W-1:0] out_tag;

    int checks;
    int errors;

    cmp_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .taken     (taken),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic        cond;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    // Backpressure sequence data, indexed by tag 1..3.
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [2:0]  bp_op[4];
    logic        bp_cond[4];
    logic [3:0]  bp_flg[4];

    task automatic drive_idle();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = 3'b000;
        in_tag   = '0;
    endtask

    initial begin
        int next_tag;
        int exp_tag;
        bit stalled;
        logic [WIDTH-1:0] snap_result;
        logic [3:0] snap_flags;
        logic [TAG_W-1:0] snap_tag;

        checks = 0;
        errors = 0;

        //         a             b             op   tag  cond flags NZCV
        vecs[0]  = '{32'd5,        32'd7,        LT,  4'd3,  1'b1, 4'b1000};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,        LTU, 4'd4,  1'b0, 4'b1010};
        vecs[2]  = '{32'hFFFFFFFF, 32'd1,        LT,  4'd5,  1'b1, 4'b1010};
        vecs[3]  = '{32'h80000000, 32'd1,        LT,  4'd6,  1'b1, 4'b0011};
        vecs[4]  = '{32'h80000000, 32'd1,        GE,  4'd7,  1'b0, 4'b0011};
        vecs[5]  = '{32'h1234,     32'h1234,     EQ,  4'd8,  1'b1, 4'b0110};
        vecs[6]  = '{32'h1234,     32'h1234,     LE,  4'd9,  1'b1, 4'b0110};
        vecs[7]  = '{32'h1234,     32'h1234,     GT,  4'd10, 1'b0, 4'b0110};
        vecs[8]  = '{32'h1234,     32'h1234,     GEU, 4'd11, 1'b1, 4'b0110};
        vecs[9]  = '{32'h80000000, 32'd0,        GEU, 4'd12, 1'b1, 4'b1010};
        vecs[10] = '{32'd3,        32'd0,        NE,  4'd13, 1'b1, 4'b0010};
        vecs[11] = '{32'd0,        32'd1,        LTU, 4'd14, 1'b1, 4'b1000};
        vecs[12] = '{32'd7,        32'd5,        LE,  4'd15, 1'b0, 4'b0010};

        bp_a[1] = 32'd5;      bp_b[1] = 32'd7;      bp_op[1] = LT;
        bp_cond[1] = 1'b1;    bp_flg[1] = 4'b1000;
        bp_a[2] = 32'h1234;   bp_b[2] = 32'h1234;   bp_op[2] = EQ;
        bp_cond[2] = 1'b1;    bp_flg[2] = 4'b0110;
        bp_a[3] = 32'd7;      bp_b[3] = 32'd5;      bp_op[3] = GT;
        bp_cond[3] = 1'b1;    bp_flg[3] = 4'b0010;
        bp_a[0] = '0; bp_b[0] = '0; bp_op[0] = EQ;
        bp_cond[0] = 1'b0; bp_flg[0] = '0;

        // Reset, with in_valid asserted to show it is ignored.
        reset     = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_taken", 64'(taken), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("rst_no_accept", 64'(out_valid), 64'd0);

        // Stream the table back-to-back; vector i appears in cycle i+2.
        for (int i = 0; i < NV + 2; i++) begin
            @(posedge clk);
            #1;
            if (i < NV) begin
                in_valid = 1'b1;
                a        = vecs[i].a;
                b        = vecs[i].b;
                op       = vecs[i].op;
                in_tag   = vecs[i].tag;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (i < 2) begin
                chk("stream_latency", 64'(out_valid), 64'd0);
            end else begin
                chk($sformatf("v%0d_valid", i - 2), 64'(out_valid), 64'd1);
                chk($sformatf("v%0d_result", i - 2), 64'(result),
                    64'(vecs[i-2].cond));
                chk($sformatf("v%0d_taken", i - 2), 64'(taken),
                    64'(vecs[i-2].cond));
                chk($sformatf("v%0d_flags", i - 2), 64'(flags),
                    64'(vecs[i-2].flg));
                chk($sformatf("v%0d_tag", i - 2), 64'(out_tag),
                    64'(vecs[i-2].tag));
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: tags 1,2,3 offered, out_ready low for 4 cycles.
        next_tag = 1;
        exp_tag  = 1;
        stalled  = 1'b0;
        snap_result = '0;
        snap_flags  = '0;
        snap_tag    = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = (cyc >= 4);
            if (next_tag <= 3) begin
                in_valid = 1'b1;
                a        = bp_a[next_tag];
                b        = bp_b[next_tag];
                op       = bp_op[next_tag];
                in_tag   = 4'(next_tag);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                chk("bp_full_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            if (cyc == 4)
                chk("bp_in_ready_high", 64'(in_ready), 64'd1);
            if (stalled) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_result", 64'(result), 64'(snap_result));
                chk("bp_hold_flags", 64'(flags), 64'(snap_flags));
                chk("bp_hold_tag", 64'(out_tag), 64'(snap_tag));
            end
            stalled = out_valid & ~out_ready;
            if (stalled) begin
                snap_result = result;
                snap_flags  = flags;
                snap_tag    = out_tag;
            end
            if (out_valid && out_ready) begin
                chk("bp_order_tag", 64'(out_tag), 64'(exp_tag));
                if (exp_tag <= 3) begin
                    chk("bp_result", 64'(result), 64'(bp_cond[exp_tag]));
                    chk("bp_flags", 64'(flags), 64'(bp_flg[exp_tag]));
                end
                exp_tag++;
            end
            if (in_valid && in_ready)
                next_tag++;
        end
        chk("bp_all_delivered", 64'(exp_tag), 64'd4);

        // Mid-flight reset with both stages full.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'd5; b = 32'd7; op = LT; in_tag = 4'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; a = 32'd9; b = 32'd2; op = GT; in_tag = 4'd2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b1; a = 32'd1; b = 32'd1; op = EQ; in_tag = 4'd7;
        @(negedge clk);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 32'd1; b = 32'd2; op = LTU; in_tag = 4'd9;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_taken", 64'(taken), 64'd0);
        chk("mid_rst_flags", 64'(flags), 64'd0);
        chk("mid_rst_tag", 64'(out_tag), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        chk("post_rst_lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", 64'(result), 64'd1);
        chk("post_rst_flags", 64'(flags), 64'(4'b1000));
        chk("post_rst_tag", 64'(out_tag), 64'd9);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_single", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
